key_debounce: RTL and testbench

Multi-channel push-button conditioner that sits directly upstream of the combinational gate examples. It takes raw, bouncing, asynchronous board keys and produces clean, synchronous levels suitable for driving gate inputs `a` and `b`. It also produces single-cycle press and release strobes per channel. All channels are independent and identical.

---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/key_debounce.sv | 29 ++
 tb/tb_key_debounce.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared encodings and reset constants for the key debouncer.
package key_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_e;

    // Keys are active-low, so the idle (released) level is 1.
    localparam logic KEY_IDLE = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 2-flop synchronizer, stability FSM with counter, and
// registered level plus single-cycle press/release strobes.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_state_q, key_state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        sync1_d     = key_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (sync2_q != key_state_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHECK: begin
                // Any return to the committed level discards the partial window.
                if (sync2_q == key_state_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    key_state_d = sync2_q;
                    press_d     = ~sync2_q;
                    release_d   = sync2_q;
                    state_d     = ST_STABLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= KEY_IDLE;
            sync2_q     <= KEY_IDLE;
            state_q     <= ST_STABLE;
            cnt_q       <= '0;
            key_state_q <= KEY_IDLE;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: WIDTH independent debounce channels.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] key_state,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random keys,
// compared every cycle against a sliding-window reference model.
module tb_key_debounce;

    localparam int W = 2;
    localparam int S = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] key_in;
    logic [W-1:0] key_state;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;
    logic         and_out;

    int vectors     = 0;
    int miscompares = 0;
    logic anyStrobe = 1'b0;

    key_debounce #(
        .WIDTH(W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release)
    );

    // Gate example downstream: AND of the two (inverted, active-low) keys.
    assign and_out = ~key_state[0] & ~key_state[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a key's level flips once the last S values seen by the
    // debouncer (key_in delayed two edges) all differ from the current level.
    logic [W-1:0] m_sync1, m_sync2, m_state, m_press, m_release;
    logic [S-1:0] m_hist [W];
    logic [W-1:0] n_state, n_press, n_release;
    logic [S-1:0] n_hist [W];

    always_comb begin
        n_state   = m_state;
        n_press   = '0;
        n_release = '0;
        for (int c = 0; c < W; c++) begin
            n_hist[c] = {m_hist[c][S-2:0], m_sync2[c]};
            if (m_state[c] ? (n_hist[c] == '0) : (n_hist[c] == '1)) begin
                n_state[c]   = ~m_state[c];
                n_press[c]   = m_state[c];
                n_release[c] = ~m_state[c];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync1   <= '1;
            m_sync2   <= '1;
            m_state   <= '1;
            m_press   <= '0;
            m_release <= '0;
            for (int c = 0; c < W; c++) m_hist[c] <= '1;
        end else begin
            m_sync1   <= key_in;
            m_sync2   <= m_sync1;
            m_state   <= n_state;
            m_press   <= n_press;
            m_release <= n_release;
            for (int c = 0; c < W; c++) m_hist[c] <= n_hist[c];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [6:0] act, exp;
        act = {and_out, key_state, key_press, key_release};
        exp = {~m_state[0] & ~m_state[1], m_state, m_press, m_release};
        vectors++;
        if ((key_press | key_release) != '0) anyStrobe = 1'b1;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL model-compare t=%0t: got and/state/press/release=%b expected %b",
                     $time, act, exp);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] v, input int cycles);
        key_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 2'b11;
        repeat (2) @(negedge clk);
        checkOutput("reset values", {2'b00, key_state, key_press, key_release}, 8'b00_11_00_00);
        rst_n = 1'b1;
        applyStimulus(2'b11, 3);

        // Clean press on channel 0: commit exactly S+1 edges after sampling.
        applyStimulus(2'b10, 5);
        checkOutput("press before latency", {2'b00, key_state, key_press, key_release}, 8'b00_11_00_00);
        applyStimulus(2'b10, 1);
        checkOutput("press commit", {2'b00, key_state, key_press, key_release}, 8'b00_10_01_00);
        applyStimulus(2'b10, 1);
        checkOutput("press strobe one cycle", {2'b00, key_state, key_press, key_release}, 8'b00_10_00_00);
        applyStimulus(2'b11, 8);
        checkOutput("release ch0", {6'b0, key_state}, 8'b0000_0011);

        // Bounce rejection: lows of 1, 2, 3 cycles never commit.
        anyStrobe = 1'b0;
        applyStimulus(2'b10, 1);
        applyStimulus(2'b11, 3);
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 3);
        applyStimulus(2'b10, 3);
        applyStimulus(2'b11, 8);
        checkOutput("bounce state", {6'b0, key_state}, 8'b0000_0011);
        checkOutput("bounce no strobe", {7'b0, anyStrobe}, 8'b0);

        // Bounce then settle: window restarts from the final falling sample.
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b10, 5);
        checkOutput("settle before latency", {2'b00, key_state, key_press, key_release}, 8'b00_11_00_00);
        applyStimulus(2'b10, 1);
        checkOutput("settle commit", {2'b00, key_state, key_press, key_release}, 8'b00_10_01_00);

        // Gate chain: output rises only once the second press commits.
        applyStimulus(2'b00, 5);
        checkOutput("gate before 2nd commit", {7'b0, and_out}, 8'b0);
        applyStimulus(2'b00, 1);
        checkOutput("gate after 2nd commit", {1'b0, and_out, key_state, key_press, key_release},
                    8'b01_00_10_00);

        // Simultaneous release of both channels.
        applyStimulus(2'b00, 2);
        applyStimulus(2'b11, 5);
        checkOutput("dual release before latency", {2'b00, key_state, key_press, key_release}, 8'b00_00_00_00);
        applyStimulus(2'b11, 1);
        checkOutput("dual release commit", {1'b0, and_out, key_state, key_press, key_release},
                    8'b00_11_00_11);
        applyStimulus(2'b11, 3);

        // Simultaneous press of both channels.
        applyStimulus(2'b00, 6);
        checkOutput("dual press commit", {2'b00, key_state, key_press, key_release}, 8'b00_00_11_00);
        applyStimulus(2'b11, 8);

        // Reset mid-count after two counter increments.
        applyStimulus(2'b10, 4);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset mid-count", {2'b00, key_state, key_press, key_release}, 8'b00_11_00_00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b10, 5);
        checkOutput("post-reset before latency", {6'b0, key_state}, 8'b0000_0011);
        applyStimulus(2'b10, 1);
        checkOutput("post-reset commit", {2'b00, key_state, key_press, key_release}, 8'b00_10_01_00);

        // Asynchronous reset from a committed low level, between edges.
        applyStimulus(2'b10, 2);
        #2 rst_n = 1'b0;
        #1 checkOutput("async reset from pressed", {2'b00, key_state, key_press, key_release}, 8'b00_11_00_00);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized keys with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(W'($urandom), int'($urandom_range(1, 8)));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("random async reset", {2'b00, key_state, key_press, key_release},
                               8'b00_11_00_00);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        applyStimulus(2'b11, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
